// File: rtl/dvi_timing_ctrl.sv
// Pixel-clock video timing generator: raster counters, sync/de generation and
// upstream pixel pull with sticky underflow detection; start/stop at frame boundaries.
module dvi_timing_ctrl #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0
) (
   input  logic        clk_pix,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        clear_underflow,
   input  logic        pix_valid,
   input  logic [23:0] pix_data,
   output logic        pix_ready,
   output logic        sof,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [23:0] video_data,
   output logic        running,
   output logic        underflow
);

   localparam int DATA_W = 24;

   localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
   localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] H_LAST     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
   localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] V_LAST     = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [11:0]         h, v;
   logic                active, frame_end, line_end;
   logic                h_act, v_act, h_sync_on, v_sync_on;
   logic                hsync_p1, vsync_p1, de_p1, underflow_q;
   logic [DATA_W-1:0]   video_data_p1;

   assign active    = (state != IDLE);
   assign line_end  = (h == H_LAST);
   assign frame_end = line_end && (v == V_LAST);
   assign h_act     = (h < H_ACT_END);
   assign v_act     = (v < V_ACT_END);
   assign h_sync_on = (h >= H_SYNC_BEG) && (h < H_SYNC_END);
   assign v_sync_on = (v >= V_SYNC_BEG) && (v < V_SYNC_END);

   assign pix_ready = active && h_act && v_act;
   assign sof       = active && (h == 12'd0) && (v == 12'd0);
   assign running   = active;

   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // A stop requested exactly on the frame-end cycle goes straight to IDLE
   // rather than running one more full frame in STOPPING.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (enable) state_nxt = RUN;
         RUN:      if (!enable) state_nxt = frame_end ? IDLE : STOPPING;
         STOPPING: begin
            if (enable)         state_nxt = RUN;
            else if (frame_end) state_nxt = IDLE;
         end
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         h <= 12'd0;
         v <= 12'd0;
      end else if (!active) begin
         h <= 12'd0;
         v <= 12'd0;
      end else if (line_end) begin
         h <= 12'd0;
         v <= (v == V_LAST) ? 12'd0 : v + 12'd1;
      end else begin
         h <= h + 12'd1;
      end
   end

   // Stage p1: timing outputs registered one cycle behind the counters
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         hsync_p1      <= ~HS_POL;
         vsync_p1      <= ~VS_POL;
         de_p1         <= 1'b0;
         video_data_p1 <= '0;
         underflow_q   <= 1'b0;
      end else begin
         hsync_p1      <= (active && h_sync_on) ? HS_POL : ~HS_POL;
         vsync_p1      <= (active && v_sync_on) ? VS_POL : ~VS_POL;
         de_p1         <= pix_ready;
         video_data_p1 <= (pix_ready && pix_valid) ? pix_data : '0;
         if (pix_ready && !pix_valid) underflow_q <= 1'b1;
         else if (clear_underflow)    underflow_q <= 1'b0;
      end
   end

   assign hsync      = hsync_p1;
   assign vsync      = vsync_p1;
   assign de         = de_p1;
   assign video_data = video_data_p1;
   assign underflow  = underflow_q;

endmodule
